// File: rtl/writeback_pkg.sv
// Shared opcode/funct3 constants, instruction field helpers and stage types for the writeback stage.
package writeback_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HOLD  = 2'd1,
    ST_LWAIT = 2'd2
  } wb_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [1:0]  addr_lo;
    logic [31:0] result;
  } stage_t;

  function automatic logic [6:0] inst_opcode(input logic [31:0] inst);
    return inst[6:0];
  endfunction

  function automatic logic [2:0] inst_funct3(input logic [31:0] inst);
    return inst[14:12];
  endfunction

  function automatic logic [31:0] inst_imm_i(input logic [31:0] inst);
    return {{20{inst[31]}}, inst[31:20]};
  endfunction

  // STORE, BRANCH and unknown opcodes retire without touching the register file.
  function automatic logic opcode_writes_rd(input logic [6:0] opc);
    return opc inside {OPC_OPIMM, OPC_OP, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_LOAD};
  endfunction

endpackage

// File: rtl/writeback_load_align.sv
// Load data alignment: picks the addressed byte/half from a word-aligned little-endian
// word and sign- or zero-extends it according to funct3.
module writeback_load_align
  import writeback_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [7:0]  lane [4];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign lane[gi] = rdata_i[8*gi +: 8];
  end

  assign byte_sel = lane[addr_lo_i];
  // Only addr_lo[1] selects the half, so a halfword at offset 3 reads the upper half.
  assign half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

  always_comb begin
    data_o = 32'hFFFF_FFFF;
    unique case (funct3_i)
      FUNCT3_LB:  data_o = {{24{byte_sel[7]}}, byte_sel};
      FUNCT3_LH:  data_o = {{16{half_sel[15]}}, half_sel};
      FUNCT3_LW:  data_o = rdata_i;
      FUNCT3_LBU: data_o = {24'h0, byte_sel};
      FUNCT3_LHU: data_o = {16'h0, half_sel};
      default:    data_o = 32'hFFFF_FFFF;
    endcase
  end

endmodule

// File: rtl/writeback.sv
// Writeback stage: holds one instruction from execute, waits for load data, drives the RF write port.
// Optional retired-instruction counter built when WB_INSTRET_EN is defined.
module writeback
  import writeback_pkg::*;
#(
  parameter int RF_ADDR_W = 5,
  parameter int INSTRET_W = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [31:0]          pc_i,
  input  logic [31:0]          inst_i,
  input  logic [31:0]          r0data_i,
  input  logic [31:0]          result_i,
  input  logic [31:0]          dmem_rdata_i,
  input  logic                 dmem_rvalid_i,
  output logic                 rf_we_o,
  output logic [RF_ADDR_W-1:0] rf_waddr_o,
  output logic [31:0]          rf_wdata_o,
  output logic                 busy_o,
  output logic [INSTRET_W-1:0] instret_o
);

  logic                 v_q, v_d;
  stage_t               stage_q, stage_d;
  wb_state_e            state;
  logic                 is_load;
  logic                 done;
  logic                 capture;
  logic [31:0]          addr_sum;
  logic [31:0]          load_data;
  logic [RF_ADDR_W-1:0] rd;
  logic                 unused_bits;

  assign is_load  = inst_opcode(stage_q.inst) == OPC_LOAD;
  assign rd       = stage_q.inst[7 +: RF_ADDR_W];
  assign addr_sum = r0data_i + inst_imm_i(inst_i);

  // The state is a pure decode of the stage register; there is no separate state flop.
  always_comb begin
    state = ST_EMPTY;
    if (v_q) state = is_load ? ST_LWAIT : ST_HOLD;
  end

  always_comb begin
    done    = 1'b0;
    busy_o  = 1'b0;
    ready_o = 1'b1;
    capture = 1'b0;
    v_d     = v_q;
    stage_d = stage_q;
    unique case (state)
      ST_EMPTY: ;
      ST_HOLD:  done = 1'b1;
      ST_LWAIT: begin
        done   = dmem_rvalid_i;
        busy_o = ~dmem_rvalid_i;
      end
      default: ;
    endcase
    ready_o = ~v_q | done;
    capture = valid_i & ready_o;
    if (ready_o) v_d = valid_i;
    if (capture) begin
      stage_d = '{pc: pc_i, inst: inst_i, addr_lo: addr_sum[1:0], result: result_i};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q     <= 1'b0;
      stage_q <= '0;
    end else begin
      v_q     <= v_d;
      stage_q <= stage_d;
    end
  end

  writeback_load_align u_load_align (
    .rdata_i   (dmem_rdata_i),
    .addr_lo_i (stage_q.addr_lo),
    .funct3_i  (inst_funct3(stage_q.inst)),
    .data_o    (load_data)
  );

  assign rf_we_o    = done & opcode_writes_rd(inst_opcode(stage_q.inst)) & (rd != '0);
  assign rf_waddr_o = rd;
  assign rf_wdata_o = is_load ? load_data : stage_q.result;

  assign unused_bits = ^{stage_q.pc, stage_q.inst, addr_sum[31:2]};

`ifdef WB_INSTRET_EN
  logic [INSTRET_W-1:0] instret_q, instret_d;

  always_comb begin
    instret_d = instret_q;
    if (done) instret_d = instret_q + INSTRET_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) instret_q <= '0;
    else     instret_q <= instret_d;
  end

  assign instret_o = instret_q;
`else
  assign instret_o = '0;
`endif

endmodule

// File: tb/tb_writeback.sv
// Self-checking bench for writeback: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural model.
module tb_writeback;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_i = 1'b0;
  logic [31:0] pc_i = '0, inst_i = '0, r0data_i = '0, result_i = '0, dmem_rdata_i = '0;
  logic        dmem_rvalid_i = 1'b0;
  logic        ready_o, rf_we_o, busy_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;
  logic [63:0] instret_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  writeback #(.RF_ADDR_W(5), .INSTRET_W(64)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o), .pc_i(pc_i),
    .inst_i(inst_i), .r0data_i(r0data_i), .result_i(result_i),
    .dmem_rdata_i(dmem_rdata_i), .dmem_rvalid_i(dmem_rvalid_i),
    .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
    .busy_o(busy_o), .instret_o(instret_o)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after posedge; checks happen 2 units later.
  task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] r0,
                       input logic [31:0] res, input logic [31:0] rdata,
                       input logic rv, input logic r);
    @(posedge clk);
    #1;
    valid_i = v; inst_i = inst; r0data_i = r0; result_i = res;
    dmem_rdata_i = rdata; dmem_rvalid_i = rv; rst = r; pc_i = $urandom;
    #2;
  endtask

  function automatic logic [31:0] ref_load(input logic [31:0] w, input int alo, input logic [2:0] f3);
    int unsigned b, h;
    b = (w >> (8 * alo)) & 32'hFF;
    h = (alo >= 2) ? (w >> 16) : (w & 32'hFFFF);
    case (f3)
      3'd0:    return (b >= 128) ? b - 256 : b;
      3'd1:    return (h >= 32768) ? h - 65536 : h;
      3'd2:    return w;
      3'd4:    return b;
      3'd5:    return h;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  // Behavioural model: one optional pending instruction plus a retire counter.
  bit          m_known = 0;
  bit          m_v = 0;
  logic [31:0] m_inst = '0, m_result = '0;
  int          m_alo = 0;
  logic [63:0] m_instret = '0;

  initial begin : cmp
    bit          e_load, e_done, e_ready, e_busy, e_we;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [63:0] e_instret;
    forever begin
      @(negedge clk);
      if (m_known) begin
        op      = m_inst[6:0];
        rd      = m_inst[11:7];
        e_load  = m_v && (op == 7'h03);
        e_done  = m_v && (!e_load || dmem_rvalid_i);
        e_ready = !m_v || e_done;
        e_busy  = e_load && !dmem_rvalid_i;
        e_we    = e_done && (rd != 0) &&
                  (op inside {7'h13, 7'h33, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h03});
`ifdef WB_INSTRET_EN
        e_instret = m_instret;
`else
        e_instret = 64'd0;
`endif
        chk("ready", ready_o, e_ready);
        chk("busy", busy_o, e_busy);
        chk("we", rf_we_o, e_we);
        chk("instret", instret_o, e_instret);
        if (m_v) chk("waddr", rf_waddr_o, rd);
        if (e_we) chk("wdata", rf_wdata_o,
                      e_load ? ref_load(dmem_rdata_i, m_alo, m_inst[14:12]) : m_result);
        if (rst) begin
          m_v = 0; m_instret = '0;
        end else begin
          if (e_done) m_instret = m_instret + 1;
          if (e_ready) begin
            m_v = valid_i;
            if (valid_i) begin
              m_inst   = inst_i;
              m_result = result_i;
              m_alo    = (int'(r0data_i) + int'($signed(inst_i[31:20]))) & 3;
            end
          end
        end
      end else if (rst) begin
        m_known = 1; m_v = 0; m_instret = '0;
      end
    end
  end

  localparam logic [31:0] ADDI_X5  = 32'h00A0_0293;
  localparam logic [31:0] LB_X6    = 32'h0000_0303;
  localparam logic [31:0] LHU_X7   = 32'h0000_5383;
  localparam logic [31:0] LW_X7    = 32'h0000_2383;
  localparam logic [31:0] ADDI_X0  = 32'h00A0_0013;
  localparam logic [31:0] SW_OP    = 32'h0011_2223;
  localparam logic [31:0] BEQ_OP   = 32'h0020_8463;
`ifdef WB_INSTRET_EN
  localparam logic [63:0] RETIRED7 = 64'd7;
`else
  localparam logic [63:0] RETIRED7 = 64'd0;
`endif

  logic [6:0] opcs [12] = '{7'h03, 7'h03, 7'h03, 7'h13, 7'h33, 7'h37,
                            7'h17, 7'h6F, 7'h67, 7'h23, 7'h63, 7'h7F};

  initial begin
    logic [31:0] rinst;
    drive(0, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("rst_ready", ready_o, 1);
    chk("rst_we", rf_we_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_instret", instret_o, 0);

    drive(1, ADDI_X5, 0, 10, 0, 0, 0);
    chk("addi_ready", ready_o, 1);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("addi_we", rf_we_o, 1);
    chk("addi_waddr", rf_waddr_o, 5);
    chk("addi_wdata", rf_wdata_o, 10);

    drive(1, LB_X6, 2, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 0, 32'h1280_3456, 0, 0);
      chk("lb_wait_ready", ready_o, 0);
      chk("lb_wait_busy", busy_o, 1);
      chk("lb_wait_we", rf_we_o, 0);
    end
    drive(0, 0, 0, 0, 32'h1280_3456, 1, 0);
    chk("lb_we", rf_we_o, 1);
    chk("lb_waddr", rf_waddr_o, 6);
    chk("lb_wdata", rf_wdata_o, 32'hFFFF_FF80);
    chk("lb_busy", busy_o, 0);

    drive(1, LHU_X7, 2, 0, 0, 0, 0);
    drive(1, LW_X7, 2, 0, 32'hBEEF_0000, 1, 0);
    chk("lhu_we", rf_we_o, 1);
    chk("lhu_wdata", rf_wdata_o, 32'h0000_BEEF);
    chk("lhu_ready", ready_o, 1);
    drive(0, 0, 0, 0, 32'hBEEF_0000, 1, 0);
    chk("lw_we", rf_we_o, 1);
    chk("lw_wdata", rf_wdata_o, 32'hBEEF_0000);

    drive(1, ADDI_X0, 0, 10, 0, 0, 0);
    drive(1, SW_OP, 0, 0, 0, 0, 0);
    chk("x0_we", rf_we_o, 0);
    chk("x0_ready", ready_o, 1);
    drive(1, BEQ_OP, 0, 0, 0, 0, 0);
    chk("sw_we", rf_we_o, 0);
    chk("sw_ready", ready_o, 1);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("beq_we", rf_we_o, 0);
    chk("beq_ready", ready_o, 1);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("instret_7", instret_o, RETIRED7);

    drive(1, LW_X7, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("lwait_busy", busy_o, 1);
    drive(0, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 32'h1234_5678, 1, 0);
    chk("rstld_we", rf_we_o, 0);
    chk("rstld_ready", ready_o, 1);
    chk("rstld_busy", busy_o, 0);
    chk("rstld_instret", instret_o, 0);

    for (int i = 0; i < 5; i++) begin
      drive(1, (32'(10 + i) << 7) | 32'h33, 0, 32'(100 + i), 0, 0, 0);
      if (i > 0) begin
        chk("b2b_we", rf_we_o, 1);
        chk("b2b_waddr", rf_waddr_o, 5'(10 + i - 1));
        chk("b2b_wdata", rf_wdata_o, 32'(100 + i - 1));
        chk("b2b_ready", ready_o, 1);
      end
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("b2b_last_waddr", rf_waddr_o, 14);
    chk("b2b_last_wdata", rf_wdata_o, 104);

    for (int n = 0; n < 2000; n++) begin
      rinst = $urandom;
      rinst[6:0] = opcs[$urandom_range(0, 11)];
      if ($urandom_range(0, 7) == 0) rinst[11:7] = 5'd0;
      drive($urandom_range(0, 9) < 7, rinst, $urandom, $urandom, $urandom,
            $urandom_range(0, 9) < 4, $urandom_range(0, 99) == 0);
    end
    drive(0, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
